// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 constants, FSM state codes and word-size generic round functions
// Purpose: shared K tables, initial hash values and the Ch/Maj/Sigma helpers for
//   32-bit (SHA-224/256) and 64-bit (SHA-384/512) words. Helpers take and return
//   64-bit values; 32-bit callers pass zero-extended words and keep the low half.
// Ports: none (package).
package sha2_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] IV384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                                    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [511:0] IV512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [31:0] K32 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [63:0] K64 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ws);
    if (ws == 32) return {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] ch(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int ws);
    if (ws == 32) return rotr(x, 2, ws) ^ rotr(x, 13, ws) ^ rotr(x, 22, ws);
    return rotr(x, 28, ws) ^ rotr(x, 34, ws) ^ rotr(x, 39, ws);
  endfunction

  function automatic logic [63:0] big_sigma1(input logic [63:0] x, input int ws);
    if (ws == 32) return rotr(x, 6, ws) ^ rotr(x, 11, ws) ^ rotr(x, 25, ws);
    return rotr(x, 14, ws) ^ rotr(x, 18, ws) ^ rotr(x, 41, ws);
  endfunction

  function automatic logic [63:0] small_sigma0(input logic [63:0] x, input int ws);
    if (ws == 32) return rotr(x, 7, ws) ^ rotr(x, 18, ws) ^ (x >> 3);
    return rotr(x, 1, ws) ^ rotr(x, 8, ws) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] small_sigma1(input logic [63:0] x, input int ws);
    if (ws == 32) return rotr(x, 17, ws) ^ rotr(x, 19, ws) ^ (x >> 10);
    return rotr(x, 19, ws) ^ rotr(x, 61, ws) ^ (x >> 6);
  endfunction

  function automatic logic [63:0] k_word(input logic [6:0] idx, input int ws);
    if (ws == 32) return {32'h0, K32[idx[5:0]]};
    return K64[idx];
  endfunction

  // Word i of the initial hash value (H0 = word 0); mode 1 selects the truncated variants.
  function automatic logic [63:0] iv_word(input logic m, input int i, input int ws);
    logic [255:0] v32;
    logic [511:0] v64;
    v32 = m ? IV224 : IV256;
    v64 = m ? IV384 : IV512;
    if (ws == 32) return {32'h0, v32[(7 - i) * 32 +: 32]};
    return v64[(7 - i) * 64 +: 64];
  endfunction

endpackage

// File: rtl/sha2_w_sched.sv
// rtl/sha2_w_sched.sv - SHA-2 message schedule as a 16-word shift register
// Purpose: loads a 16-word block, presents W_t on w_t and expands W_{t+16} on each shift.
// Ports: clk, rst (sync active-high), en (freezes state), load (capture block),
//   shift (advance one round), block[16*WORDSIZE] (word 0 in MSBs), w_t[WORDSIZE].
module sha2_w_sched
  import sha2_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic                    shift,
  input  logic [16*WORDSIZE-1:0]  block,
  output logic [WORDSIZE-1:0]     w_t
);

  localparam int W = WORDSIZE;

  logic [W-1:0] w [16];
  logic [W-1:0] w_next;

  // w[0] is W_t, so w[1], w[9], w[14] are W_{t+1}, W_{t+9}, W_{t+14}.
  always_comb begin
    w_next = W'(small_sigma1(64'(w[14]), W)) + w[9] + W'(small_sigma0(64'(w[1]), W)) + w[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (en) begin
      if (load) begin
        for (int i = 0; i < 16; i++) w[i] <= block[(15 - i) * W +: W];
      end else if (shift) begin
        for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
        w[15] <= w_next;
      end
    end
  end

  assign w_t = w[0];

endmodule

// File: rtl/sha2_stream_core.sv
// rtl/sha2_stream_core.sv - iterative one-round-per-cycle SHA-2 core with message chaining
// Purpose: compresses pre-padded blocks, chains state across blocks, emits H0..H7 after the
//   last block. WORDSIZE 32 -> SHA-224/256 (64 rounds), 64 -> SHA-384/512 (80 rounds);
//   other WORDSIZE values are not supported. Optional abort port when SHA2_ABORT_EN is defined.
// Ports: clk, rst (sync active-high), en (global enable), mode (0: 256/512 IV, 1: 224/384 IV),
//   in_valid/in_ready/in_first/in_last/in_block (block input), out_valid/out_ready/out_digest
//   (digest output, H0 in MSBs), busy (LOAD/ROUND/FOLD), abort (SHA2_ABORT_EN only).
module sha2_stream_core
  import sha2_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [16*WORDSIZE-1:0]  in_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORDSIZE-1:0]   out_digest,
  output logic                    busy
`ifdef SHA2_ABORT_EN
  ,
  input  logic                    abort
`endif
);

  localparam int W      = WORDSIZE;
  localparam int ROUNDS = (WORDSIZE == 32) ? 64 : 80;

  logic [2:0]   state;
  logic [6:0]   rnd;
  logic         chain_open;
  logic         fresh_q;     // block starts a new message (explicit first or no open chain)
  logic         last_q;
  logic         mode_q;
  logic [W-1:0] hc [8];      // chaining value H0..H7
  logic [W-1:0] wv [8];      // working variables a..h
  logic [W-1:0] h_init [8];
  logic [W-1:0] w_t;
  logic [W-1:0] t1;
  logic [W-1:0] t2;
  logic         abort_hit;
  logic         accept;

`ifdef SHA2_ABORT_EN
  assign abort_hit = abort & en;
`else
  assign abort_hit = 1'b0;
`endif

  // Abort wins over a transfer in the same cycle, so it also closes the input side.
  assign in_ready  = en & ~rst & ~abort_hit & (state == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_LOAD) | (state == S_ROUND) | (state == S_FOLD);

  sha2_w_sched #(.WORDSIZE(W)) u_w_sched (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (accept),
    .shift (state == S_ROUND),
    .block (in_block),
    .w_t   (w_t)
  );

  always_comb begin
    for (int i = 0; i < 8; i++) h_init[i] = fresh_q ? W'(iv_word(mode_q, i, W)) : hc[i];
  end

  always_comb begin
    t1 = wv[7] + W'(big_sigma1(64'(wv[4]), W)) + W'(ch(64'(wv[4]), 64'(wv[5]), 64'(wv[6])))
       + W'(k_word(rnd, W)) + w_t;
    t2 = W'(big_sigma0(64'(wv[0]), W)) + W'(maj(64'(wv[0]), 64'(wv[1]), 64'(wv[2])));
  end

  always_comb begin
    out_digest = '0;
    for (int i = 0; i < 8; i++) out_digest[(7 - i) * W +: W] = hc[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rnd        <= '0;
      chain_open <= 1'b0;
      fresh_q    <= 1'b0;
      last_q     <= 1'b0;
      mode_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hc[i] <= '0;
        wv[i] <= '0;
      end
    end else if (en) begin
      if (abort_hit) begin
        state      <= S_IDLE;
        chain_open <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            state   <= S_LOAD;
            last_q  <= in_last;
            fresh_q <= in_first | ~chain_open;
            // mode only matters at the start of a message; later blocks keep it
            if (in_first | ~chain_open) mode_q <= mode;
          end
          S_LOAD: begin
            for (int i = 0; i < 8; i++) begin
              wv[i] <= h_init[i];
              hc[i] <= h_init[i];
            end
            rnd   <= '0;
            state <= S_ROUND;
          end
          S_ROUND: begin
            wv[7] <= wv[6];
            wv[6] <= wv[5];
            wv[5] <= wv[4];
            wv[4] <= wv[3] + t1;
            wv[3] <= wv[2];
            wv[2] <= wv[1];
            wv[1] <= wv[0];
            wv[0] <= t1 + t2;
            rnd   <= rnd + 7'd1;
            if (rnd == 7'(ROUNDS - 1)) state <= S_FOLD;
          end
          S_FOLD: begin
            for (int i = 0; i < 8; i++) hc[i] <= hc[i] + wv[i];
            chain_open <= ~last_q;
            state      <= last_q ? S_DONE : S_IDLE;
          end
          S_DONE: if (out_ready) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
